// File: rtl/sa_weight_feeder.sv
// Weight feeder for the systolic array: buffers unskewed weight vectors and emits them with lane i delayed by i cycles.
// Build macro WFEED_STALL_EN adds stall_i, which freezes the feeder and blanks its outputs while asserted.
module sa_weight_feeder #(
  parameter int PE_SIZE    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
`ifdef WFEED_STALL_EN
  input  logic                          stall_i,
`endif
  input  logic                          start_i,
  input  logic [LEN_WIDTH-1:0]          len_i,
  output logic                          busy_o,
  output logic                          done_o,
  input  logic                          vec_valid_i,
  output logic                          vec_ready_o,
  input  logic [DATA_WIDTH*PE_SIZE-1:0] vec_data_i,
  output logic [DATA_WIDTH*PE_SIZE-1:0] weight_col_o,
  output logic [PE_SIZE-1:0]            weight_en_col_o
);
  localparam int VEC_W = DATA_WIDTH * PE_SIZE;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;
  state_t state, state_nxt;

  logic stall;
`ifdef WFEED_STALL_EN
  assign stall = stall_i;
`else
  assign stall = 1'b0;
`endif

  logic [VEC_W-1:0]     fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     fifo_cnt;
  logic                 fifo_full, fifo_empty;
  logic [LEN_WIDTH-1:0] len_q, acc_cnt, pop_cnt;
  logic                 start_ok;
  logic                 push_p0, pop_p0, last_p0;
  logic [VEC_W-1:0]     rd_data_p0;
  logic [PE_SIZE-1:0]   vld_p, last_p;

  assign fifo_full   = (fifo_cnt == CNT_FULL);
  assign fifo_empty  = (fifo_cnt == '0);
  assign start_ok    = (state == S_IDLE) && start_i && (len_i != '0);
  assign vec_ready_o = (state == S_STREAM) && !fifo_full && (acc_cnt < len_q) && !stall;
  assign push_p0     = vec_valid_i && vec_ready_o;
  assign pop_p0      = (state == S_STREAM) && !fifo_empty && (pop_cnt < len_q) && !stall;
  assign rd_data_p0  = fifo_mem[rd_ptr];
  // pop_cnt < len_q whenever this matters, so the increment cannot overflow
  assign last_p0     = pop_p0 && ((pop_cnt + LEN_ONE) == len_q);

  always_ff @(posedge clk) begin
    if (push_p0) fifo_mem[wr_ptr] <= vec_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      len_q    <= '0;
      acc_cnt  <= '0;
      pop_cnt  <= '0;
    end else begin
      if (start_ok) begin
        len_q   <= len_i;
        acc_cnt <= '0;
        pop_cnt <= '0;
      end
      if (push_p0) begin
        wr_ptr  <= wr_ptr + PTR_ONE;
        acc_cnt <= acc_cnt + LEN_ONE;
      end
      if (pop_p0) begin
        rd_ptr  <= rd_ptr + PTR_ONE;
        pop_cnt <= pop_cnt + LEN_ONE;
      end
      case ({push_p0, pop_p0})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
        2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start_ok) state_nxt = S_STREAM;
      S_STREAM: begin
        if (done_o)                 state_nxt = S_IDLE;
        else if (pop_cnt == len_q)  state_nxt = S_DRAIN;
      end
      S_DRAIN:  if (done_o) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // ---- pop stage -> skew stages: enable and end-of-tile marker travel with the data ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p  <= '0;
      last_p <= '0;
    end else if (!stall) begin
      vld_p[0]  <= pop_p0;
      last_p[0] <= last_p0;
      for (int k = 1; k < PE_SIZE; k++) begin
        vld_p[k]  <= vld_p[k-1];
        last_p[k] <= last_p[k-1];
      end
    end
  end

  for (genvar i = 0; i < PE_SIZE; i++) begin : g_lane
    // lane i keeps i+1 stages so its element leaves i cycles after lane 0
    logic [DATA_WIDTH-1:0] lane_p [i+1];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k <= i; k++) lane_p[k] <= '0;
      end else if (!stall) begin
        lane_p[0] <= pop_p0 ? rd_data_p0[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int k = 1; k <= i; k++) lane_p[k] <= lane_p[k-1];
      end
    end

    assign weight_col_o[i*DATA_WIDTH +: DATA_WIDTH] = stall ? '0 : lane_p[i];
  end

  assign weight_en_col_o = stall ? '0 : vld_p;
  assign done_o          = last_p[PE_SIZE-1] && !stall;
  assign busy_o          = (state != S_IDLE);

endmodule

// File: tb/tb_sa_weight_feeder.sv
// Directed self-checking bench for sa_weight_feeder (PE_SIZE=2, DATA_WIDTH=8, FIFO_DEPTH=4, LEN_WIDTH=8).
`timescale 1ns/1ps
module tb_sa_weight_feeder;
  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [7:0]  len_i;
  logic        busy_o, done_o;
  logic        vec_valid_i, vec_ready_o;
  logic [15:0] vec_data_i;
  logic [15:0] weight_col_o;
  logic [1:0]  weight_en_col_o;
`ifdef WFEED_STALL_EN
  logic        stall_i;
`endif

  int n_vec = 0;
  int n_bad = 0;

  sa_weight_feeder #(.PE_SIZE(2), .DATA_WIDTH(8), .FIFO_DEPTH(4), .LEN_WIDTH(8)) dut (
    .clk             (clk),
    .rst             (rst),
`ifdef WFEED_STALL_EN
    .stall_i         (stall_i),
`endif
    .start_i         (start_i),
    .len_i           (len_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .vec_valid_i     (vec_valid_i),
    .vec_ready_o     (vec_ready_o),
    .vec_data_i      (vec_data_i),
    .weight_col_o    (weight_col_o),
    .weight_en_col_o (weight_en_col_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    start_i     = 1'b0;
    len_i       = 8'd0;
    vec_valid_i = 1'b0;
    vec_data_i  = 16'h0000;
`ifdef WFEED_STALL_EN
    stall_i     = 1'b0;
`endif
  endtask

  task automatic chk_all(input string tag, input logic [15:0] col, input logic [1:0] en,
                         input logic done, input logic busy, input logic rdy);
    chk({tag, ".col"},  32'(weight_col_o),    32'(col));
    chk({tag, ".en"},   32'(weight_en_col_o), 32'(en));
    chk({tag, ".done"}, 32'(done_o),          32'(done));
    chk({tag, ".busy"}, 32'(busy_o),          32'(busy));
    chk({tag, ".rdy"},  32'(vec_ready_o),     32'(rdy));
  endtask

  // Tile of two vectors 'h0103, 'h0204; second push delayed by gap cycles,
  // optional spurious starts mid-tile, optional stall of sh cycles from cycle 3 (gap must be 0 then).
  task automatic run_tile(input string nm, input int gap, input bit noise, input int sh);
    logic [15:0] ecol;
    logic [1:0]  een;
    for (int c = 0; c <= 7 + gap + sh; c++) begin
      start_i     = (c == 0) || (noise && c >= 2 && c <= 4);
      len_i       = (c == 0) ? 8'd2 : 8'd5;
      vec_valid_i = (c == 1) || (c == 2 + gap);
      vec_data_i  = (c == 1) ? 16'h0103 : ((c == 2 + gap) ? 16'h0204 : 16'hdead);
`ifdef WFEED_STALL_EN
      stall_i     = (c >= 3) && (c < 3 + sh);
`endif
      #1;
      ecol = 16'h0000;
      een  = 2'b00;
      if (c == 3 + sh)       begin ecol[7:0]  = 8'h03; een[0] = 1'b1; end
      if (c == 4 + gap + sh) begin ecol[7:0]  = 8'h04; een[0] = 1'b1; end
      if (c == 4 + sh)       begin ecol[15:8] = 8'h01; een[1] = 1'b1; end
      if (c == 5 + gap + sh) begin ecol[15:8] = 8'h02; een[1] = 1'b1; end
      chk_all($sformatf("%s.c%0d", nm, c), ecol, een, c == 5 + gap + sh,
              (c >= 1) && (c <= 5 + gap + sh), (c >= 1) && (c <= 2 + gap));
      step();
    end
    idle_inputs();
  endtask

  initial begin
    int xfers;
    int dones;
    int done_cyc;
    logic [15:0] ecol;
    logic [1:0]  een;

    rst = 1'b1;
    idle_inputs();
    step();
    step();
    chk_all("reset", 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();

    run_tile("basic", 0, 1'b0, 0);
    run_tile("bubble", 2, 1'b0, 0);
    run_tile("midstart", 0, 1'b1, 0);

    // zero-length start is ignored
    start_i = 1'b1;
    len_i   = 8'd0;
    step();
    idle_inputs();
    #1;
    chk("len0.busy", 32'(busy_o), 32'd0);
    chk("len0.rdy", 32'(vec_ready_o), 32'd0);
    step();
    chk("len0.busy2", 32'(busy_o), 32'd0);

    // len 8 with valid held high: lane0 carries j at cycle j+2, lane1 carries 80+j at j+3
    xfers    = 0;
    dones    = 0;
    done_cyc = -1;
    for (int c = 0; c <= 13; c++) begin
      start_i     = (c == 0);
      len_i       = 8'd8;
      vec_valid_i = (c >= 1);
      vec_data_i  = {8'h80 + 8'(xfers + 1), 8'(xfers + 1)};
      #1;
      ecol = 16'h0000;
      een  = 2'b00;
      if (c - 2 >= 1 && c - 2 <= 8) begin ecol[7:0]  = 8'(c - 2);         een[0] = 1'b1; end
      if (c - 3 >= 1 && c - 3 <= 8) begin ecol[15:8] = 8'h80 + 8'(c - 3); een[1] = 1'b1; end
      chk($sformatf("bp.c%0d.col", c), 32'(weight_col_o), 32'(ecol));
      chk($sformatf("bp.c%0d.en", c), 32'(weight_en_col_o), 32'(een));
      chk($sformatf("bp.c%0d.rdy", c), 32'(vec_ready_o), 32'((c >= 1) && (c <= 8)));
      if (vec_valid_i && vec_ready_o) xfers++;
      if (done_o) begin dones++; done_cyc = c; end
      step();
    end
    idle_inputs();
    chk("bp.xfers", 32'(xfers), 32'd8);
    chk("bp.dones", 32'(dones), 32'd1);
    chk("bp.done_cyc", 32'(done_cyc), 32'd11);
    chk("bp.busy_end", 32'(busy_o), 32'd0);

    // reset mid-stream aborts the tile
    start_i = 1'b1; len_i = 8'd4;
    step();
    idle_inputs();
    vec_valid_i = 1'b1; vec_data_i = 16'h1111;
    step();
    vec_data_i = 16'h2222;
    step();
    idle_inputs();
    rst = 1'b1;
    step();
    #1;
    chk_all("rst_mid.a", 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    #1;
    chk_all("rst_mid.b", 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (done_o || weight_en_col_o != 2'b00) dones++;
    end
    chk("rst_mid.quiet", 32'(dones), 32'd0);
    run_tile("after_rst", 0, 1'b0, 0);

`ifdef WFEED_STALL_EN
    run_tile("stall", 0, 1'b0, 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
